// File: rtl/egress_gen_cpld_pkg.sv
// Shared PCIe definitions for the completion-with-data generator:
// request header layout, FSM states, completion status codes,
// CplD fmt/type constants and the register-read offset map.
package egress_gen_cpld_pkg;

  localparam int PCIE_DATA_WIDTH = 128;
  localparam int PCIE_DATA_KW    = PCIE_DATA_WIDTH / 8;

  // Memory-read request header as presented by the ingress decoder.
  typedef struct packed {
    logic [3:0]  channel;
    logic [3:0]  offset;
    logic [9:0]  length;
    logic [7:0]  tag;
    logic [15:0] req_id;
    logic [2:0]  tc;
    logic [2:0]  attr;
    logic [31:0] addr;
  } tlp_head_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REG_RD    = 2'd1,
    ST_WAIT_DATA = 2'd2,
    ST_SEND      = 2'd3
  } cpld_state_e;

  // Completion status codes
  localparam logic [2:0] CPL_STATUS_SC = 3'b000;
  localparam logic [2:0] CPL_STATUS_UR = 3'b001;
  localparam logic [2:0] CPL_STATUS_CA = 3'b100;

  // CplD header constants
  localparam logic [2:0]  CPLD_FMT      = 3'b010;
  localparam logic [4:0]  CPLD_TYPE     = 5'b01010;
  localparam logic [9:0]  CPLD_LEN_DW   = 10'd1;
  localparam logic [11:0] CPLD_BYTE_CNT = 12'd4;
  localparam logic [PCIE_DATA_KW-1:0] CPLD_KEEP = 16'hFFFF;

  // Readable offsets
  localparam logic [3:0] OFF_RX_REG      = 4'b1000;
  localparam logic [3:0] OFF_RX_XFER_LEN = 4'b1001;
  localparam logic [3:0] OFF_TX_REG      = 4'b1010;
  localparam logic [3:0] OFF_TX_XFER_LEN = 4'b1011;

  // {register[2:0], action[1:0]} field placed in rd_tdest[8:4]
  localparam logic [4:0] MAP_RX_REG      = {3'b000, 2'b01};
  localparam logic [4:0] MAP_RX_XFER_LEN = {3'b010, 2'b01};
  localparam logic [4:0] MAP_TX_REG      = {3'b000, 2'b00};
  localparam logic [4:0] MAP_TX_XFER_LEN = {3'b010, 2'b00};

  typedef struct packed {
    logic       mapped;
    logic [4:0] field;
  } rd_map_t;

  // Translate a request offset into the register/action field.
  function automatic rd_map_t rd_map(input logic [3:0] offset);
    rd_map_t m;
    m.mapped = 1'b1;
    case (offset)
      OFF_RX_REG:      m.field = MAP_RX_REG;
      OFF_RX_XFER_LEN: m.field = MAP_RX_XFER_LEN;
      OFF_TX_REG:      m.field = MAP_TX_REG;
      OFF_TX_XFER_LEN: m.field = MAP_TX_XFER_LEN;
      default: begin
        m.mapped = 1'b0;
        m.field  = 5'b00000;
      end
    endcase
    return m;
  endfunction

endpackage

// File: rtl/egress_gen_cpld.sv
// Completion-with-data generator: accepts one memory-read request at a
// time, reads the addressed register over the rd_* port and returns a
// single-beat 128-bit CplD (3DW header + 1DW payload).
// Optional feature macro: CPLD_TIMEOUT_EN (abort a register read that
// does not return within TIMEOUT_CYC cycles with status CA).
module egress_gen_cpld
  import egress_gen_cpld_pkg::*;
#(
  parameter int          TIMEOUT_CYC = 256,
  parameter logic [31:0] BAD_DATA    = 32'hFFFF_FFFF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  tlp_head_t                  rdreq_meta,
  input  logic                       rdreq_valid,
  output logic                       rdreq_rdy,
  output logic                       rd_req,
  output logic [9:0]                 rd_tdest,
  input  logic [31:0]                rd_tdata,
  input  logic                       rd_tvalid,
  input  logic [15:0]                cfg_completer_id,
  output logic [PCIE_DATA_WIDTH-1:0] cpld_data,
  output logic [PCIE_DATA_KW-1:0]    cpld_keep,
  output logic                       cpld_valid,
  output logic                       cpld_last,
  input  logic                       cpld_rdy
);

  if (PCIE_DATA_WIDTH != 128) begin : g_width_chk
    $error("egress_gen_cpld requires a 128-bit completion bus");
  end
  if (TIMEOUT_CYC < 2) begin : g_timeout_chk
    $error("TIMEOUT_CYC must be at least 2");
  end

  cpld_state_e state_q, state_d;

  // Latched header fields needed to build the completion
  logic [2:0]  tc_q, tc_d;
  logic [2:0]  attr_q, attr_d;
  logic [15:0] req_id_q, req_id_d;
  logic [7:0]  tag_q, tag_d;
  logic [4:0]  laddr_q, laddr_d;

  logic                       rd_req_q, rd_req_d;
  logic [9:0]                 rd_tdest_q, rd_tdest_d;
  logic [PCIE_DATA_WIDTH-1:0] cpld_data_q, cpld_data_d;
  logic [PCIE_DATA_KW-1:0]    cpld_keep_q, cpld_keep_d;
  logic                       cpld_valid_q, cpld_valid_d;
  logic                       cpld_last_q, cpld_last_d;

  logic        load_cpl_s;
  logic [2:0]  cpl_status_s;
  logic [31:0] cpl_payload_s;
  rd_map_t     map_s;

  // Only address bits [6:2] feed the completion lower-address field.
  logic unused_addr_s;
  assign unused_addr_s = ^{rdreq_meta.addr[31:7], rdreq_meta.addr[1:0]};

`ifdef CPLD_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
`endif

  // Pack the 3DW CplD header and its single payload DW into one beat.
  function automatic logic [127:0] build_cpld(
    input logic [2:0]  tc,
    input logic [2:0]  attr,
    input logic [15:0] cid,
    input logic [15:0] req_id,
    input logic [7:0]  tag,
    input logic [4:0]  laddr,
    input logic [2:0]  status,
    input logic [31:0] payload
  );
    logic [31:0] dw0, dw1, dw2;
    dw0 = {CPLD_FMT, CPLD_TYPE, 1'b0, tc, 1'b0, attr[2], 1'b0, 1'b0,
           1'b0, 1'b0, attr[1:0], 2'b00, CPLD_LEN_DW};
    dw1 = {cid, status, 1'b0, CPLD_BYTE_CNT};
    dw2 = {req_id, tag, 1'b0, laddr, 2'b00};
    return {payload, dw2, dw1, dw0};
  endfunction

  assign map_s = rd_map(rdreq_meta.offset);

  // Next-state and registered-output logic for the request/completion FSM.
  always_comb begin
    state_d       = state_q;
    tc_d          = tc_q;
    attr_d        = attr_q;
    req_id_d      = req_id_q;
    tag_d         = tag_q;
    laddr_d       = laddr_q;
    rd_req_d      = 1'b0;
    rd_tdest_d    = rd_tdest_q;
    cpld_data_d   = cpld_data_q;
    cpld_keep_d   = cpld_keep_q;
    cpld_valid_d  = cpld_valid_q;
    cpld_last_d   = cpld_last_q;
    load_cpl_s    = 1'b0;
    cpl_status_s  = CPL_STATUS_SC;
    cpl_payload_s = BAD_DATA;
`ifdef CPLD_TIMEOUT_EN
    to_cnt_d      = {CNT_W{1'b0}};
`endif

    case (state_q)
      ST_IDLE: begin
        if (rdreq_valid) begin
          tc_d     = rdreq_meta.tc;
          attr_d   = rdreq_meta.attr;
          req_id_d = rdreq_meta.req_id;
          tag_d    = rdreq_meta.tag;
          laddr_d  = rdreq_meta.addr[6:2];
          if (rdreq_meta.length != CPLD_LEN_DW) begin
            // Only single-DW register reads are supported
            cpl_status_s = CPL_STATUS_UR;
            load_cpl_s   = 1'b1;
            state_d      = ST_SEND;
          end else if (!map_s.mapped) begin
            // Unmapped offsets read as BAD_DATA with a successful status
            load_cpl_s = 1'b1;
            state_d    = ST_SEND;
          end else begin
            rd_req_d   = 1'b1;
            rd_tdest_d = {1'b0, map_s.field, rdreq_meta.channel};
            state_d    = ST_REG_RD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_REG_RD: begin
        state_d = ST_WAIT_DATA;
      end

      ST_WAIT_DATA: begin
        if (rd_tvalid) begin
          cpl_payload_s = rd_tdata;
          load_cpl_s    = 1'b1;
          state_d       = ST_SEND;
        end else begin
`ifdef CPLD_TIMEOUT_EN
          if (to_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            cpl_status_s = CPL_STATUS_CA;
            load_cpl_s   = 1'b1;
            state_d      = ST_SEND;
          end else begin
            to_cnt_d = to_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
`else
          state_d = ST_WAIT_DATA;
`endif
        end
      end

      ST_SEND: begin
        if (cpld_rdy) begin
          cpld_valid_d = 1'b0;
          cpld_last_d  = 1'b0;
          state_d      = ST_IDLE;
        end else begin
          state_d = ST_SEND;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (load_cpl_s) begin
      cpld_data_d  = build_cpld(tc_d, attr_d, cfg_completer_id, req_id_d,
                                tag_d, laddr_d, cpl_status_s, cpl_payload_s);
      cpld_keep_d  = CPLD_KEEP;
      cpld_valid_d = 1'b1;
      cpld_last_d  = 1'b1;
    end else begin
      cpld_valid_d = cpld_valid_d;
    end
  end

  // State and output registers; reset drops any pending request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      tc_q         <= 3'b000;
      attr_q       <= 3'b000;
      req_id_q     <= 16'h0000;
      tag_q        <= 8'h00;
      laddr_q      <= 5'b00000;
      rd_req_q     <= 1'b0;
      rd_tdest_q   <= 10'h000;
      cpld_data_q  <= {PCIE_DATA_WIDTH{1'b0}};
      cpld_keep_q  <= {PCIE_DATA_KW{1'b0}};
      cpld_valid_q <= 1'b0;
      cpld_last_q  <= 1'b0;
`ifdef CPLD_TIMEOUT_EN
      to_cnt_q     <= {CNT_W{1'b0}};
`endif
    end else begin
      state_q      <= state_d;
      tc_q         <= tc_d;
      attr_q       <= attr_d;
      req_id_q     <= req_id_d;
      tag_q        <= tag_d;
      laddr_q      <= laddr_d;
      rd_req_q     <= rd_req_d;
      rd_tdest_q   <= rd_tdest_d;
      cpld_data_q  <= cpld_data_d;
      cpld_keep_q  <= cpld_keep_d;
      cpld_valid_q <= cpld_valid_d;
      cpld_last_q  <= cpld_last_d;
`ifdef CPLD_TIMEOUT_EN
      to_cnt_q     <= to_cnt_d;
`endif
    end
  end

  assign rdreq_rdy  = (state_q == ST_IDLE);
  assign rd_req     = rd_req_q;
  assign rd_tdest   = rd_tdest_q;
  assign cpld_data  = cpld_data_q;
  assign cpld_keep  = cpld_keep_q;
  assign cpld_valid = cpld_valid_q;
  assign cpld_last  = cpld_last_q;

endmodule

// File: tb/tb_egress_gen_cpld.sv
// Randomized self-checking bench for egress_gen_cpld with a
// transaction-level reference model of the completion it must return.
module tb_egress_gen_cpld;
  import egress_gen_cpld_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  tlp_head_t    rdreq_meta;
  logic         rdreq_valid;
  logic         rdreq_rdy;
  logic         rd_req;
  logic [9:0]   rd_tdest;
  logic [31:0]  rd_tdata;
  logic         rd_tvalid;
  logic [15:0]  cfg_completer_id;
  logic [127:0] cpld_data;
  logic [15:0]  cpld_keep;
  logic         cpld_valid;
  logic         cpld_last;
  logic         cpld_rdy;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  egress_gen_cpld dut (
    .clk              (clk),
    .rst              (rst),
    .rdreq_meta       (rdreq_meta),
    .rdreq_valid      (rdreq_valid),
    .rdreq_rdy        (rdreq_rdy),
    .rd_req           (rd_req),
    .rd_tdest         (rd_tdest),
    .rd_tdata         (rd_tdata),
    .rd_tvalid        (rd_tvalid),
    .cfg_completer_id (cfg_completer_id),
    .cpld_data        (cpld_data),
    .cpld_keep        (cpld_keep),
    .cpld_valid       (cpld_valid),
    .cpld_last        (cpld_last),
    .cpld_rdy         (cpld_rdy)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Register/action code for an offset, or -1 when the offset is unmapped.
  function automatic int ref_region(input logic [3:0] off);
    case (off)
      4'd8:    return 1;   // {000,01}
      4'd9:    return 9;   // {010,01} RX transferred length
      4'd10:   return 0;   // {000,00}
      4'd11:   return 8;   // {010,00} TX transferred length
      default: return -1;
    endcase
  endfunction

  // Expected completion beat: DW0 in the low 32 bits, payload in DW3.
  function automatic logic [127:0] ref_cpld(input tlp_head_t h, input logic [2:0] st,
                                            input logic [31:0] pl, input logic [15:0] cid);
    logic [31:0] dw0, dw1, dw2;
    dw0 = {3'b010, 5'b01010, 1'b0, h.tc, 1'b0, h.attr[2], 4'b0000, h.attr[1:0], 2'b00, 10'd1};
    dw1 = {cid, st, 1'b0, 12'd4};
    dw2 = {h.req_id, h.tag, 1'b0, h.addr[6:2], 2'b00};
    return {pl, dw2, dw1, dw0};
  endfunction

  function automatic tlp_head_t rand_head();
    tlp_head_t h;
    h.channel = 4'($urandom);
    h.offset  = ($urandom_range(0, 9) < 7) ? 4'(8 + $urandom_range(0, 3)) : 4'($urandom);
    h.length  = ($urandom_range(0, 9) < 8) ? 10'd1 : 10'($urandom);
    h.tag     = 8'($urandom);
    h.req_id  = 16'($urandom);
    h.tc      = 3'($urandom);
    h.attr    = 3'($urandom);
    h.addr    = $urandom;
    return h;
  endfunction

  // One full request: issue, serve the register read, check the
  // completion, apply bp cycles of backpressure and finish the handshake.
  task automatic run_req(input tlp_head_t h, input int rd_lat, input int bp,
                         input logic [31:0] data, input bit spurious,
                         input bit to_exp, input int max_wait);
    bit          ur, reads, seen, busy_bad, hold_bad;
    int          code, cyc, nreq, req_cyc, exp_lat;
    logic [9:0]  tdest_seen;
    logic [2:0]  exp_st;
    logic [31:0] exp_pl;
    logic [127:0] exp_beat;
    ur    = (h.length != 10'd1);
    code  = ref_region(h.offset);
    reads = !ur && (code >= 0);
    exp_st  = ur ? 3'b001 : (to_exp ? 3'b100 : 3'b000);
    exp_pl  = (reads && !to_exp) ? data : 32'hFFFF_FFFF;
    exp_lat = !reads ? 1 : (to_exp ? 258 : rd_lat + 2);
    check("rdy_idle", rdreq_rdy, 1'b1);
    rdreq_meta  = h;
    rdreq_valid = 1'b1;
    @(posedge clk); #1;
    rdreq_valid = 1'b0;
    rdreq_meta  = rand_head();
    cyc = 1; nreq = 0; req_cyc = 0; seen = 0; busy_bad = 0; tdest_seen = 10'h000;
    while (1) begin
      rd_tvalid = 1'b0;
      if (rdreq_rdy) busy_bad = 1;
      if (rd_req) begin
        nreq++;
        req_cyc    = cyc;
        tdest_seen = rd_tdest;
      end
      if (cpld_valid) begin
        seen = 1;
        break;
      end
      if (cyc >= max_wait) break;
      rd_tdata = $urandom;
      if (reads && !to_exp && cyc == 1 + rd_lat) begin
        rd_tvalid = 1'b1;
        rd_tdata  = data;
      end else if (spurious && cyc == 1) begin
        rd_tvalid = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    rd_tvalid = 1'b0;
    check("cpl_seen", seen, 1'b1);
    if (!seen) return;
    check("latency", cyc, exp_lat);
    check("rd_req_cnt", nreq, reads ? 1 : 0);
    if (reads) begin
      check("rd_req_cyc", req_cyc, 1);
      check("rd_tdest", tdest_seen, {1'b0, 5'(code), h.channel});
    end
    exp_beat = ref_cpld(h, exp_st, exp_pl, cfg_completer_id);
    check("cpld_data", cpld_data, exp_beat);
    check("cpld_keep", cpld_keep, 16'hFFFF);
    check("cpld_last", cpld_last, 1'b1);
    hold_bad = 0;
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      if (cpld_data !== exp_beat || cpld_valid !== 1'b1 || cpld_last !== 1'b1 ||
          cpld_keep !== 16'hFFFF) hold_bad = 1;
      if (rdreq_rdy) busy_bad = 1;
    end
    check("hold_stable", hold_bad, 1'b0);
    check("rdy_busy", busy_bad, 1'b0);
    cpld_rdy = 1'b1;
    @(posedge clk); #1;
    cpld_rdy = 1'b0;
    check("cpl_done", cpld_valid, 1'b0);
    check("rdy_back", rdreq_rdy, 1'b1);
  endtask

  initial begin
    tlp_head_t h;
    bit        bad;
    rst = 1'b1; rdreq_valid = 1'b0; rdreq_meta = '0; rd_tdata = 32'h0;
    rd_tvalid = 1'b0; cpld_rdy = 1'b0; cfg_completer_id = 16'hA5C3;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rd_req", rd_req, 1'b0);
    check("rst_tdest", rd_tdest, 10'h000);
    check("rst_valid", cpld_valid, 1'b0);
    check("rst_last", cpld_last, 1'b0);
    check("rst_data", cpld_data, 128'h0);
    check("rst_keep", cpld_keep, 16'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_rdy", rdreq_rdy, 1'b1);

    // Register read of RX transferred length, ch 3, minimum latency
    h = rand_head(); h.channel = 4'd3; h.offset = 4'b1001; h.tag = 8'h5A; h.length = 10'd1;
    run_req(h, 1, 0, 32'h0000_1000, 1'b0, 1'b0, 50);
    // Backpressure for 5 cycles
    h = rand_head(); h.offset = 4'b1000; h.length = 10'd1;
    run_req(h, 2, 5, 32'hDEAD_BEEF, 1'b1, 1'b0, 50);
    // Unmapped offset
    h = rand_head(); h.offset = 4'b1111; h.length = 10'd1;
    run_req(h, 1, 0, 32'h1234_5678, 1'b0, 1'b0, 50);
    // Length 2 and length 0 are unsupported
    h = rand_head(); h.offset = 4'b1010; h.length = 10'd2;
    run_req(h, 1, 1, 32'h1234_5678, 1'b0, 1'b0, 50);
    h = rand_head(); h.offset = 4'b1011; h.length = 10'd0;
    run_req(h, 1, 0, 32'h1234_5678, 1'b0, 1'b0, 50);
    // Remaining mapped offsets
    for (int k = 8; k < 12; k++) begin
      h = rand_head(); h.offset = 4'(k); h.length = 10'd1;
      run_req(h, $urandom_range(1, 3), $urandom_range(0, 2), $urandom, 1'b0, 1'b0, 50);
    end
    // Random traffic
    for (int k = 0; k < 40; k++) begin
      cfg_completer_id = 16'($urandom);
      run_req(rand_head(), $urandom_range(1, 6), $urandom_range(0, 4), $urandom,
              1'($urandom), 1'b0, 50);
    end

    // Register read that never returns
    h = rand_head(); h.offset = 4'b1001; h.length = 10'd1;
`ifdef CPLD_TIMEOUT_EN
    run_req(h, 1000, 1, 32'h0, 1'b0, 1'b1, 400);
`else
    rdreq_meta = h; rdreq_valid = 1'b1;
    @(posedge clk); #1;
    rdreq_valid = 1'b0;
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      if (cpld_valid) bad = 1;
      @(posedge clk); #1;
    end
    check("no_timeout_cpl", bad, 1'b0);
    check("still_busy", rdreq_rdy, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
`endif

    // Reset while waiting for register data
    h = rand_head(); h.offset = 4'b1011; h.length = 10'd1;
    rdreq_meta = h; rdreq_valid = 1'b1;
    @(posedge clk); #1;
    rdreq_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    check("mid_rst_valid", cpld_valid, 1'b0);
    check("mid_rst_tdest", rd_tdest, 10'h000);
    check("mid_rst_data", cpld_data, 128'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    rd_tvalid = 1'b1; rd_tdata = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    rd_tvalid = 1'b0;
    check("post_rst_rdy", rdreq_rdy, 1'b1);
    check("post_rst_valid", cpld_valid, 1'b0);
    @(posedge clk); #1;
    check("post_rst_valid2", cpld_valid, 1'b0);
    h = rand_head(); h.offset = 4'b1001; h.length = 10'd1;
    run_req(h, 3, 2, 32'hCAFE_0001, 1'b1, 1'b0, 50);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
